// File: rtl/instr_mem_loader.sv
// Program loader: packs a byte stream into little-endian words and writes them from address 0 while holding the core in reset.
// Latency: 5 cycles per word (4 byte accepts + 1 write); byte_ready is high only in RECV, so a stalled source simply pauses the load.
module instr_mem_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_write_en,
  output logic [31:0]      mem_write_address,
  output logic [31:0]      mem_write_data,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       byte_idx, byte_idx_nxt;
  logic [CNT_W-1:0] word_idx, word_idx_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic [31:0]      asm_word, asm_nxt;
  logic [31:0]      addr_nxt, data_nxt;
  logic             busy_nxt, hold_nxt, error_nxt;
  logic             start_ok, last_word;

  assign start_ok  = (word_count != '0) && (word_count <= DEPTH_C);
  assign last_word = (word_idx == (count_q - ONE_C));

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    word_idx_nxt = word_idx;
    count_nxt    = count_q;
    asm_nxt      = asm_word;
    addr_nxt     = mem_write_address;
    data_nxt     = mem_write_data;
    busy_nxt     = busy;
    hold_nxt     = cpu_hold;
    error_nxt    = error;

    case (state)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            count_nxt    = word_count;
            byte_idx_nxt = '0;
            word_idx_nxt = '0;
            asm_nxt      = '0;
            error_nxt    = 1'b0;
            busy_nxt     = 1'b1;
            hold_nxt     = 1'b1;
            state_nxt    = RECV;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end

      RECV: begin
        // abort wins over a byte offered in the same cycle
        if (abort) begin
          state_nxt    = IDLE;
          error_nxt    = 1'b1;
          busy_nxt     = 1'b0;
          hold_nxt     = 1'b1;
          byte_idx_nxt = '0;
          asm_nxt      = '0;
        end else if (byte_valid) begin
          asm_nxt[{byte_idx, 3'b000} +: 8] = byte_data;
          byte_idx_nxt = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            addr_nxt  = 32'(word_idx) << 2;
            data_nxt  = {byte_data, asm_word[23:0]};
            state_nxt = WRITE;
          end
        end
      end

      WRITE: begin
        if (abort) begin
          state_nxt    = IDLE;
          error_nxt    = 1'b1;
          busy_nxt     = 1'b0;
          hold_nxt     = 1'b1;
          byte_idx_nxt = '0;
          asm_nxt      = '0;
        end else begin
          word_idx_nxt = word_idx + ONE_C;
          byte_idx_nxt = '0;
          asm_nxt      = '0;
          state_nxt    = last_word ? DONE : RECV;
        end
      end

      DONE: begin
        busy_nxt  = 1'b0;
        hold_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      byte_idx          <= '0;
      word_idx          <= '0;
      count_q           <= '0;
      asm_word          <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      busy              <= 1'b0;
      cpu_hold          <= 1'b1;
      error             <= 1'b0;
    end else begin
      state             <= state_nxt;
      byte_idx          <= byte_idx_nxt;
      word_idx          <= word_idx_nxt;
      count_q           <= count_nxt;
      asm_word          <= asm_nxt;
      mem_write_address <= addr_nxt;
      mem_write_data    <= data_nxt;
      busy              <= busy_nxt;
      cpu_hold          <= hold_nxt;
      error             <= error_nxt;
    end
  end

  // The strobe is gated by abort and reset so a cancelled write never reaches the store.
  assign byte_ready   = (state == RECV);
  assign done         = (state == DONE);
  assign mem_write_en = (state == WRITE) && reset && !abort;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed loads with a byte-level write scoreboard plus hand-computed timing and data.
module tb_instr_mem_loader;
  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             reset, start, abort, byte_valid;
  logic [CNT_W-1:0] word_count;
  logic [7:0]       byte_data;
  logic             byte_ready, mem_write_en, cpu_hold, busy, done, error;
  logic [31:0]      mem_write_address, mem_write_data;

  instr_mem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_write_en(mem_write_en), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  bit          chk_on = 1'b0;
  wr_t         exp_q[$];
  logic [7:0]  prog [0:15];
  int          wr_cycles[$];
  logic [31:0] first_addr, first_data, last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write strobe must match the oldest word the bench saw completed.
  always @(negedge clk) begin
    wr_t e;
    if (chk_on) begin
      chk("ready_and_write", 32'(byte_ready & mem_write_en), 0);
      chk("busy_without_hold", 32'(busy & ~cpu_hold), 0);
      if (mem_write_en === 1'b1) begin
        chk("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write_addr", mem_write_address, e.addr);
          chk("write_data", mem_write_data, e.data);
        end
      end
    end
  end

  task automatic set_single();
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h50; prog[3] = 8'h00;
  endtask

  task automatic set_three();
    prog[0] = 8'h93; prog[1]  = 8'h00; prog[2]  = 8'h10; prog[3]  = 8'h00;
    prog[4] = 8'h13; prog[5]  = 8'h01; prog[6]  = 8'h20; prog[7]  = 8'h00;
    prog[8] = 8'hb3; prog[9]  = 8'h81; prog[10] = 8'h20; prog[11] = 8'h00;
  endtask

  // Cycle 0 carries start; bytes are offered from cycle 1. Returns the cycle done was seen (-1 if never).
  task automatic run_load(input int n, input int stall_at, input int stall_len,
                          input int abort_bi, input int rst_word, output int done_cyc);
    int  bi, cyc, stalls;
    bit  acc, finished, rst_next;
    wr_t e;
    wr_cycles.delete();
    first_addr = '1; first_data = '1; last_data = '1;
    done_cyc = -1;
    start = 1'b1;
    word_count = CNT_W'(n);
    step();
    start = 1'b0;
    cyc = 1; bi = 0; stalls = 0; finished = 1'b0; rst_next = 1'b0;
    while (!finished) begin
      abort = 1'b0;
      if (bi == stall_at && stalls < stall_len) begin
        byte_valid = 1'b0;
        stalls++;
      end else if (bi < 4 * n) begin
        byte_valid = 1'b1;
        byte_data  = prog[bi];
        abort      = (bi == abort_bi);
      end else begin
        byte_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 1) chk("start_accept", 32'({busy, cpu_hold, error}), 32'b110);
      acc = byte_valid && byte_ready && !abort;
      if (mem_write_en) begin
        wr_cycles.push_back(cyc);
        if (wr_cycles.size() == 1) begin
          first_addr = mem_write_address;
          first_data = mem_write_data;
        end
        last_data = mem_write_data;
      end
      if (acc && (bi % 4) == 3) begin
        if (bi / 4 == rst_word) begin
          rst_next = 1'b1;
        end else begin
          e.addr = 32'(bi / 4 * 4);
          e.data = {prog[bi], prog[bi-1], prog[bi-2], prog[bi-3]};
          exp_q.push_back(e);
        end
      end
      if (done) begin
        done_cyc = cyc;
        finished = 1'b1;
      end
      if (abort) finished = 1'b1;
      step();
      if (acc) bi++;
      cyc++;
      if (rst_next && !finished) begin
        reset = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        chk("rst_write_suppressed", 32'(mem_write_en), 0);
        step();
        reset = 1'b1;
        finished = 1'b1;
      end
      if (!finished && cyc > 300) begin
        chk("load_timeout_done", 32'(done), 1);
        finished = 1'b1;
      end
    end
    byte_valid = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int dc;
    reset = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    byte_data = '0; word_count = '0;

    // Reset then idle
    step(); step();
    @(negedge clk);
    chk_on = 1'b1;
    chk("reset_flags", 32'({byte_ready, mem_write_en, busy, done, error, cpu_hold}), 32'b000001);
    chk("reset_addr", mem_write_address, 0);
    chk("reset_data", mem_write_data, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_flags", 32'({byte_ready, mem_write_en, busy, done, error, cpu_hold}), 32'b000001);
      chk("idle_addr_data", mem_write_address | mem_write_data, 0);
      step();
    end

    // Single word
    set_single();
    run_load(1, -1, 0, -1, -1, dc);
    chk("single_wr_count", wr_cycles.size(), 1);
    if (wr_cycles.size() >= 1) chk("single_wr_cycle", wr_cycles[0], 5);
    chk("single_addr", first_addr, 32'h0);
    chk("single_data", first_data, 32'h00500013);
    chk("single_done_cycle", dc, 6);
    @(negedge clk);
    chk("single_release", 32'({cpu_hold, busy, done}), 0);
    step();

    // Three words with a 2-cycle stall inside the second word
    set_three();
    run_load(3, 5, 2, -1, -1, dc);
    chk("three_wr_count", wr_cycles.size(), 3);
    if (wr_cycles.size() == 3) begin
      chk("three_wr_cycle0", wr_cycles[0], 5);
      chk("three_wr_cycle1", wr_cycles[1], 12);
      chk("three_wr_cycle2", wr_cycles[2], 17);
    end
    chk("three_first_data", first_data, 32'h00100093);
    chk("three_last_data", last_data, 32'h002081b3);
    chk("three_done_cycle", dc, 18);
    @(negedge clk);
    chk("three_release", 32'({cpu_hold, busy, done}), 0);
    step();

    // Bad counts are rejected; core stays released
    start = 1'b1; word_count = 7'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("bad0_flags", 32'({error, busy, cpu_hold, byte_ready}), 32'b1000);
    step(); step();
    start = 1'b1; word_count = 7'd65;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("bad65_flags", 32'({error, busy, cpu_hold, byte_ready}), 32'b1000);
    step(); step();
    @(negedge clk);
    chk("bad_error_sticky", 32'(error), 1);
    step();
    set_single();
    run_load(1, -1, 0, -1, -1, dc);
    chk("after_bad_done_cycle", dc, 6);
    step();

    // Abort while the third byte of the second word is offered
    set_three();
    run_load(3, -1, 0, 6, -1, dc);
    @(negedge clk);
    chk("abort_flags", 32'({byte_ready, busy, cpu_hold, error, mem_write_en, done}), 32'b001100);
    chk("abort_wr_count", wr_cycles.size(), 1);
    chk("abort_no_done", dc, -1);
    step(); step();

    // Reset during the first WRITE cycle, then a clean reload from address 0
    run_load(2, -1, 0, -1, 0, dc);
    @(negedge clk);
    chk("rst_flags", 32'({byte_ready, busy, cpu_hold, error, mem_write_en}), 32'b00100);
    chk("rst_wr_count", wr_cycles.size(), 0);
    step();
    set_single();
    run_load(1, -1, 0, -1, -1, dc);
    chk("reload_addr", first_addr, 32'h0);
    chk("reload_data", first_data, 32'h00500013);
    chk("reload_done_cycle", dc, 6);
    step(); step();

    chk("pending_writes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
